// File: rtl/audio_pcm_decimator.sv
// Stereo boxcar decimator: averages 2^DECIM_LOG2 ock-rate samples
// per channel and queues each decimated pair in a small FIFO.
module audio_pcm_decimator #(
  parameter int DW         = 32,
  parameter int DECIM_LOG2 = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ock,
  input  logic              en,
  input  logic [DW-1:0]     din_l,
  input  logic [DW-1:0]     din_r,
  output logic [DW-1:0]     dout_l,
  output logic [DW-1:0]     dout_r,
  output logic              valid,
  input  logic              ready,
  output logic [FIFO_AW:0]  level,
  output logic              ovf
);

  localparam int AW    = DW + DECIM_LOG2;
  localparam int DEPTH = 1 << FIFO_AW;

  logic                  s1;
  logic                  s2;
  logic                  s3;
  logic                  ock_rise;

  logic [AW-1:0]         acc_l;
  logic [AW-1:0]         acc_r;
  logic [AW-1:0]         sum_l;
  logic [AW-1:0]         sum_r;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  last;
  logic                  push;

  logic [DW-1:0]         mem_l [DEPTH];
  logic [DW-1:0]         mem_r [DEPTH];
  logic [FIFO_AW:0]      wp;
  logic [FIFO_AW:0]      rp;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  do_push;

  // Bring ock into clk domain and keep one history flop for edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ock;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ock_rise = s2 & ~s3;

  assign sum_l = acc_l + {{DECIM_LOG2{1'b0}}, din_l};
  assign sum_r = acc_r + {{DECIM_LOG2{1'b0}}, din_r};
  assign last  = (cnt == {DECIM_LOG2{1'b1}});
  assign push  = ock_rise & en & last;

  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                 (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign valid = ~empty;
  assign pop   = valid & ready;

  // A full FIFO still accepts a pair when the head leaves the same cycle
  assign do_push = push & (~full | pop);
  assign level   = wp - rp;

  assign dout_l = mem_l[rp[FIFO_AW-1:0]];
  assign dout_r = mem_r[rp[FIFO_AW-1:0]];

  // Per-channel accumulation and block phase counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_l <= '0;
      acc_r <= '0;
      cnt   <= '0;
    end else if (!en) begin
      acc_l <= '0;
      acc_r <= '0;
      cnt   <= '0;
    end else if (ock_rise) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        acc_l <= '0;
        acc_r <= '0;
      end else begin
        acc_l <= sum_l;
        acc_r <= sum_r;
      end
    end
  end

  // Sticky overflow: a finished pair found no room
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (!en) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
    end
  end

  // FIFO storage, cleared so the head reads 0 after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else if (do_push) begin
      mem_l[wp[FIFO_AW-1:0]] <= sum_l[AW-1:DECIM_LOG2];
      mem_r[wp[FIFO_AW-1:0]] <= sum_r[AW-1:DECIM_LOG2];
    end
  end

endmodule

// File: doc/audio_pcm_decimator.md
Name: audio_pcm_decimator

Overview:
- Sits directly downstream of audio_pdm_demodulator.
- Consumes the stereo 32-bit samples (dout_l/dout_r) produced at the oversampling clock (ock) rate.
- Boxcar-averages 2^DECIM_LOG2 consecutive samples per channel and pushes each decimated stereo pair into a small FIFO.
- The FIFO is drained by a downstream consumer over a valid/ready handshake.

Parameters:
- DW, 32, sample width per channel (unsigned offset-binary, as produced by the demodulator).
- DECIM_LOG2, 4, log2 of the decimation ratio (default ratio 16); legal range 1..8.
- FIFO_AW, 2, log2 of FIFO depth in stereo pairs (default depth 4).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- ock  input  1  oversampling clock; asynchronous to clk, slower than clk/4.
- en  input  1  decimator enable; low clears the accumulators, counter and ovf.
- din_l  input  DW  left-channel sample; stable around each ock rising edge.
- din_r  input  DW  right-channel sample; stable around each ock rising edge.
- dout_l  output  DW  left decimated sample at the FIFO head.
- dout_r  output  DW  right decimated sample at the FIFO head.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts the head pair when valid&&ready at a clk rising edge.
- level  output  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.
- ovf  output  1  sticky flag: a decimated pair was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock (clk); reset (rstn) is asynchronous and active-low. All state resets asynchronously on rstn low.
- Reset values: dout_l=0, dout_r=0, valid=0, level=0, ovf=0; accumulators, phase counter, FIFO pointers and synchronizer flops are 0.
- ock sync:
  - ock passes through a 2-flop synchronizer plus one history flop.
  - ock_rise = s2 & ~s3, a single-clk pulse, 2-3 clk after the true ock edge.
  - din_l/din_r are captured on the ock_rise cycle.
- Accumulation:
  - Accumulators acc_l/acc_r are DW+DECIM_LOG2 bits wide, unsigned, with zero-extended inputs.
  - The full-scale sum never wraps.
  - Phase counter cnt is DECIM_LOG2 bits wide.
  - On ock_rise with en=1 and cnt != 2^DECIM_LOG2-1: acc += din, cnt += 1.
  - On ock_rise with en=1 and cnt == 2^DECIM_LOG2-1: sum = acc + din; push sum[DW+DECIM_LOG2-1:DECIM_LOG2] per channel (truncating shift, no rounding); acc=0; cnt wraps to 0.
- Latency: the pushed pair is visible at dout and valid=1 on the clk edge after the final ock_rise cycle, provided the FIFO was empty.
- en low:
  - acc=0, cnt=0, ovf cleared; ock_rise is ignored.
  - FIFO contents are retained and remain drainable.
  - On re-enable, the next ock_rise starts a fresh block.
- FIFO:
  - Synchronous, depth 2^FIFO_AW pairs, pointers FIFO_AW+1 bits wide.
  - dout_l/dout_r are driven combinationally from the head entry; they are 0 after reset, and their value is don't-care while valid=0 otherwise.
  - Pop on valid&&ready.
  - Push while full and no pop: the new pair is discarded, the FIFO is unchanged, and ovf is set (sticky until en low or reset).
  - Push and pop in the same cycle while full: both occur, level is unchanged, no overflow.
  - Push and pop in the same cycle while empty: impossible, because valid=0 so no pop; the pushed pair appears next cycle.
  - ready while valid=0 has no effect.
  - level updates the same edge as push/pop.
  - Ordering is strict FIFO.
- Reset mid-block: partial accumulation is discarded and the FIFO emptied; the first block after rstn rises spans the next 2^DECIM_LOG2 ock_rise pulses.

Test Plan:
- Constant input: en=1, ready=1, din_l=0x40000000, din_r=0xC0000000, 64 ock periods -> 4 pairs, each exactly 0x40000000/0xC0000000, valid high 1 clk per pair, ovf=0.
- Full-scale: din_l=din_r=0xFFFFFFFF for 16 ock -> dout=0xFFFFFFFF both channels (no wrap). Then din=0 for 16 ock -> 0x00000000.
- Ramp: din_l=k for k=0..15 in one block -> dout_l=7 (120>>4, truncation); din_r=15-k -> dout_r=7.
- Overflow: ready=0, 6 blocks of constant values 1..6 -> level=4, ovf=1 after the 5th block. Then ready=1 drains 1,2,3,4 in order and blocks 5-6 are lost. en low clears ovf.
- Full with simultaneous push/pop: FIFO at level 4, ready=1 held on the push cycle -> level stays 4, ovf=0, the new pair is last in the drain order.
- en low after 7 ock of a block, then high -> the next output is the average of the 16 samples after re-enable only. Asserting rstn low mid-block -> valid=0, level=0 immediately (async), no stale pair emitted afterwards.
